mul_seq_n: RTL and testbench
============================

# mul_seq_n

Parametrised sequential shift-add multiplier with a valid/ready handshake on both sides. It computes one N×N product per transaction, in unsigned or two's-complement signed mode selected per operation. It is the area-optimised successor to the combinational array multiplier: one adder and one shift register replace N−1 ripple adders. It sits between a producer and a consumer stream in datapath blocks where throughput of one product per N+2 cycles is acceptable.

## Interface
- N, default 8, operand width in bits; legal range N ≥ 2.
- clk  input  1  rising-edge clock; the only clock in the block.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  producer offers operands.
- in_ready  output  1  block can accept operands this cycle.
- a  input  N  multiplicand.
- b  input  N  multiplier.
- signed_mode  input  1  1: a, b, res are two's complement; 0: unsigned. Sampled with a and b.
- out_valid  output  1  res holds a completed product.
- out_ready  input  1  consumer accepts res.
- res  output  2N  product.

## Operation
- Three states: IDLE, RUN and DONE. A counter of width clog2(N)+1 counts RUN cycles.
- IDLE:
  - in_ready=1 and out_valid=0.
  - When in_valid && in_ready at a clock edge, the block captures:
    - mcand = |a|, zero-extended to 2N bits;
    - mplier = |b|, N bits;
    - neg = signed_mode & (a[N-1] ^ b[N-1]).
  - The accumulator clears to 0, the counter clears to 0 and the state goes to RUN.
  - In unsigned mode |x| = x. In signed mode |x| = −x if x[N-1]=1.
  - |−2^(N-1)| = 2^(N-1). This fits in N bits unsigned and needs no special case.
- RUN, one step per cycle:
  - if mplier[0]=1, acc ← acc + mcand (2N-bit add, no overflow possible);
  - mcand ← mcand << 1;
  - mplier ← mplier >> 1;
  - counter increments.
- On the edge where the counter goes from N−1 to N, the final step completes in the same edge:
  - res ← neg ? −(acc_next) : acc_next, two's complement in 2N bits;
  - the state goes to DONE.
- DONE:
  - out_valid=1 and in_ready=0.
  - res and out_valid hold stable until out_valid && out_ready at a clock edge. The state then goes to IDLE.
- The block does not accept new operands in the same cycle as the DONE handshake.
- Operands, signed_mode and in_valid are ignored outside IDLE. Changing them during RUN or DONE has no effect.
- out_ready is ignored outside DONE.
- Result range:
  - unsigned: 0 … (2^N−1)²;
  - signed: −2^(N-1)·(2^(N-1)−1) … 2^(2N-2).
  - All values are exact in 2N bits. No saturation or overflow flag exists.

## Timing
- Reset, asynchronous assertion, effective immediately:
  - state=IDLE, in_ready=1, out_valid=0, res=0;
  - internal accumulator, counter and shift registers are 0.
- Reset release: the first accept can occur on the first rising edge after rst deasserts.
- Reset mid-RUN or mid-DONE aborts the operation. No out_valid is produced for the aborted operation.
- Latency: out_valid rises exactly N cycles after the accepting edge. This is fixed and does not depend on operand values; there is no early termination.
- Minimum initiation interval: N+2 cycles (accept, N RUN edges, DONE handshake edge, then IDLE).
- in_ready is a pure function of state: registered decode, with no combinational path from in_valid.
- out_valid is a pure function of state, with no combinational path from out_ready.
- res changes only on the final RUN edge and on reset.

## Test plan
- Reset behaviour: assert rst asynchronously between clock edges -> outputs show in_ready=1, out_valid=0, res=0 before the next edge.
- Unsigned basic product, N=8: a=13, b=11, signed_mode=0 -> out_valid N=8 cycles after accept, res=0x008F.
- Unsigned maximum, N=8: a=255, b=255, signed_mode=0 -> res=0xFE01.
- Signed products, N=8:
  - −3×5 (a=0xFD, b=0x05) -> res=0xFFF1;
  - −128×−128 -> res=0x4000;
  - −128×127 -> res=0xC080;
  - 0×−1 -> res=0x0000.
- Backpressure and ignored inputs:
  - hold out_ready=0 for 5 cycles in DONE -> res and out_valid stable, in_ready=0;
  - toggle a, b and in_valid during RUN -> result unaffected;
  - after the handshake -> in_ready=1 on the next cycle, and back-to-back operations achieve an initiation interval of N+2.
- Reset mid-operation:
  - assert rst at RUN cycle 4 -> no out_valid for that operation;
  - then issue 7×9 unsigned -> res=0x003F after 8 cycles;
  - repeat with N=3 (a=7, b=7, unsigned -> res=49, latency 3) to cover parametrisation.

Source files
------------

// File: rtl/mul_seq_n.sv
// ---------------------------------------------------------------------------
// mul_seq_n -- sequential shift-add multiplier, N x N -> 2N bits.
//
// Computes one product per transaction, unsigned or two's-complement signed
// (chosen per operation by signed_mode). The operand magnitudes are multiplied
// unsigned, one multiplier bit per cycle, and the sign is applied on the last
// step. A transaction takes N RUN cycles; the minimum initiation interval is
// N+2 cycles (accept, N RUN edges, DONE handshake).
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   in_valid     producer offers a, b, signed_mode
//   in_ready     block is IDLE and will take operands on the next edge
//   a, b         N-bit multiplicand / multiplier
//   signed_mode  1: operands and result are two's complement, 0: unsigned
//   out_valid    res holds a completed product (held until out_ready)
//   out_ready    consumer accepts res
//   res          2N-bit product
// ---------------------------------------------------------------------------
module mul_seq_n #(
   parameter int N = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     a,
   input  logic [N-1:0]     b,
   input  logic             signed_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2*N-1:0]   res
);

   localparam int CW = $clog2(N) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q,     state_d;
   logic [2*N-1:0]   acc_q,       acc_d;
   logic [2*N-1:0]   mcand_q,     mcand_d;
   logic [N-1:0]     mplier_q,    mplier_d;
   logic             neg_q,       neg_d;
   logic [CW-1:0]    cnt_q,       cnt_d;
   logic [2*N-1:0]   res_q,       res_d;
   logic             in_ready_q,  in_ready_d;
   logic             out_valid_q, out_valid_d;

   logic [N-1:0]     abs_a;
   logic [N-1:0]     abs_b;
   logic [2*N-1:0]   acc_step;

   always_comb begin
      // NOTE: every _d takes its _q value first, so no path through the case
      // leaves a variable unassigned and no latch is inferred.
      state_d  = state_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      neg_d    = neg_q;
      cnt_d    = cnt_q;
      res_d    = res_q;

      // Magnitudes. The most negative value negates to itself, which read as
      // unsigned N bits is exactly its magnitude, so it needs no special case.
      abs_a = (signed_mode && a[N-1]) ? ({N{1'b0}} - a) : a;
      abs_b = (signed_mode && b[N-1]) ? ({N{1'b0}} - b) : b;

      // One shift-add step; the accumulator never exceeds (2^N-1)^2.
      acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               mcand_d  = {{N{1'b0}}, abs_a};
               mplier_d = abs_b;
               neg_d    = signed_mode & (a[N-1] ^ b[N-1]);
               acc_d    = '0;
               cnt_d    = '0;
               state_d  = RUN;
            end
         end
         RUN: begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            // Final step: sign is applied to the just-computed sum in the
            // same edge, so res is ready together with out_valid.
            if (cnt_q == CW'(N - 1)) begin
               res_d   = neg_q ? ({(2*N){1'b0}} - acc_step) : acc_step;
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Handshake outputs are registered decodes of the next state, so
      // neither has a combinational path from in_valid or out_ready.
      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         mcand_q     <= '0;
         mplier_q    <= '0;
         neg_q       <= 1'b0;
         cnt_q       <= '0;
         res_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the pre-edge
         // values computed above, independent of statement order.
         state_q     <= state_d;
         acc_q       <= acc_d;
         mcand_q     <= mcand_d;
         mplier_q    <= mplier_d;
         neg_q       <= neg_d;
         cnt_q       <= cnt_d;
         res_q       <= res_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign res       = res_q;

endmodule

// File: tb/tb_mul_seq_n.sv
// ---------------------------------------------------------------------------
// tb_mul_seq_n -- self-checking bench for mul_seq_n at N=8 and N=3.
// Expected products are pushed to a per-instance queue when operands are
// accepted and popped when the DUT presents out_valid.
// ---------------------------------------------------------------------------
module tb_mul_seq_n;

   logic        clk;
   logic        rst;

   logic        iv8, ir8, sm8, ov8, or8;
   logic [7:0]  a8, b8;
   logic [15:0] r8;

   logic        iv3, ir3, sm3, ov3, or3;
   logic [2:0]  a3, b3;
   logic [5:0]  r3;

   int checks = 0;
   int errors = 0;

   logic [15:0] q8[$];
   logic [5:0]  q3[$];

   mul_seq_n #(.N(8)) dut8 (
      .clk(clk), .rst(rst),
      .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .signed_mode(sm8),
      .out_valid(ov8), .out_ready(or8), .res(r8)
   );

   mul_seq_n #(.N(3)) dut3 (
      .clk(clk), .rst(rst),
      .in_valid(iv3), .in_ready(ir3), .a(a3), .b(b3), .signed_mode(sm3),
      .out_valid(ov3), .out_ready(or3), .res(r3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [15:0] model8(input logic [7:0] x, input logic [7:0] y,
                                          input logic sm);
      int sx, sy, p;
      sx = sm ? int'($signed(x)) : int'(x);
      sy = sm ? int'($signed(y)) : int'(y);
      p  = sx * sy;
      return p[15:0];
   endfunction

   // Full N=8 transaction: accept, check latency, check result, handshake.
   task automatic do_op8(input logic [7:0] av, input logic [7:0] bv, input logic sm,
                         input logic [15:0] exp_r, input string name);
      int n;
      logic [15:0] e;
      n = 0;
      while (ir8 !== 1'b1 && n < 20) begin
         @(posedge clk); #1; n++;
      end
      checks++;
      if (ir8 !== 1'b1) begin
         errors++; $display("FAIL %s_in_ready got %b want 1", name, ir8);
      end
      a8 = av; b8 = bv; sm8 = sm; iv8 = 1'b1;
      @(posedge clk);
      q8.push_back(exp_r);
      #1; iv8 = 1'b0;
      n = 0;
      while (ov8 !== 1'b1 && n < 40) begin
         @(posedge clk); #1; n++;
      end
      checks++;
      if (n != 8) begin
         errors++; $display("FAIL %s_latency got %0d want 8", name, n);
      end
      e = q8.pop_front();
      checks++;
      if (r8 !== e) begin
         errors++; $display("FAIL %s_res got %h want %h", name, r8, e);
      end
      or8 = 1'b1;
      @(posedge clk); #1;
      or8 = 1'b0;
      checks++;
      if (ov8 !== 1'b0 || ir8 !== 1'b1) begin
         errors++; $display("FAIL %s_after_handshake got ov=%b ir=%b want ov=0 ir=1",
                            name, ov8, ir8);
      end
   endtask

   task automatic do_op3(input logic [2:0] av, input logic [2:0] bv, input logic sm,
                         input logic [5:0] exp_r, input string name);
      int n;
      logic [5:0] e;
      n = 0;
      while (ir3 !== 1'b1 && n < 20) begin
         @(posedge clk); #1; n++;
      end
      a3 = av; b3 = bv; sm3 = sm; iv3 = 1'b1;
      @(posedge clk);
      q3.push_back(exp_r);
      #1; iv3 = 1'b0;
      n = 0;
      while (ov3 !== 1'b1 && n < 40) begin
         @(posedge clk); #1; n++;
      end
      checks++;
      if (n != 3) begin
         errors++; $display("FAIL %s_latency got %0d want 3", name, n);
      end
      e = q3.pop_front();
      checks++;
      if (r3 !== e) begin
         errors++; $display("FAIL %s_res got %h want %h", name, r3, e);
      end
      or3 = 1'b1;
      @(posedge clk); #1;
      or3 = 1'b0;
   endtask

   task automatic test_reset();
      int n;
      rst = 1'b1;
      iv8 = 1'b0; or8 = 1'b0; a8 = '0; b8 = '0; sm8 = 1'b0;
      iv3 = 1'b0; or3 = 1'b0; a3 = '0; b3 = '0; sm3 = 1'b0;
      #12;
      checks++;
      if ({ir8, ov8, r8} !== {1'b1, 1'b0, 16'h0000}) begin
         errors++; $display("FAIL reset8 got ir=%b ov=%b res=%h want ir=1 ov=0 res=0000",
                            ir8, ov8, r8);
      end
      checks++;
      if ({ir3, ov3, r3} !== {1'b1, 1'b0, 6'h00}) begin
         errors++; $display("FAIL reset3 got ir=%b ov=%b res=%h want ir=1 ov=0 res=00",
                            ir3, ov3, r3);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      // Park N=8 in DONE with a non-zero result, then reset between edges.
      a8 = 8'd13; b8 = 8'd11; iv8 = 1'b1;
      @(posedge clk); #1; iv8 = 1'b0;
      n = 0;
      while (ov8 !== 1'b1 && n < 40) begin
         @(posedge clk); #1; n++;
      end
      checks++;
      if (ov8 !== 1'b1 || r8 !== 16'h008F) begin
         errors++; $display("FAIL pre_async_reset got ov=%b res=%h want ov=1 res=008f", ov8, r8);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({ir8, ov8, r8} !== {1'b1, 1'b0, 16'h0000}) begin
         errors++; $display("FAIL async_reset got ir=%b ov=%b res=%h want ir=1 ov=0 res=0000",
                            ir8, ov8, r8);
      end
      #1 rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_unsigned();
      do_op8(8'd13,  8'd11,  1'b0, 16'h008F, "u_13x11");
      do_op8(8'd255, 8'd255, 1'b0, 16'hFE01, "u_max");
   endtask

   task automatic test_signed();
      do_op8(8'hFD, 8'h05, 1'b1, 16'hFFF1, "s_m3x5");
      do_op8(8'h80, 8'h80, 1'b1, 16'h4000, "s_m128xm128");
      do_op8(8'h80, 8'h7F, 1'b1, 16'hC080, "s_m128x127");
      do_op8(8'h00, 8'hFF, 1'b1, 16'h0000, "s_0xm1");
   endtask

   task automatic test_random();
      logic [7:0] ra, rb;
      logic rs;
      for (int i = 0; i < 6; i++) begin
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         rs = 1'($urandom_range(0, 1));
         do_op8(ra, rb, rs, model8(ra, rb, rs), "random");
      end
   endtask

   task automatic test_backpressure();
      int n;
      logic [15:0] e;
      a8 = 8'h9C; b8 = 8'h37; sm8 = 1'b1; iv8 = 1'b1;
      @(posedge clk);
      q8.push_back(model8(8'h9C, 8'h37, 1'b1));
      #1;
      n = 0;
      while (ov8 !== 1'b1 && n < 40) begin
         iv8 = 1'b0;
         @(posedge clk); #1; n++;
      end
      e = q8.pop_front();
      // Offer fresh operands while stalled in DONE; they must be ignored.
      iv8 = 1'b1; a8 = 8'h11; b8 = 8'h22; sm8 = 1'b0; or8 = 1'b0;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (ov8 !== 1'b1 || ir8 !== 1'b0 || r8 !== e) begin
            errors++; $display("FAIL stall_%0d got ov=%b ir=%b res=%h want ov=1 ir=0 res=%h",
                               i, ov8, ir8, r8, e);
         end
         @(posedge clk); #1;
      end
      or8 = 1'b1;
      @(posedge clk); #1;
      iv8 = 1'b0; or8 = 1'b0;
      checks++;
      if (ov8 !== 1'b0 || ir8 !== 1'b1) begin
         errors++; $display("FAIL no_accept_on_handshake got ov=%b ir=%b want ov=0 ir=1",
                            ov8, ir8);
      end
   endtask

   task automatic test_ignored_inputs();
      int n;
      logic [15:0] e;
      a8 = 8'hB5; b8 = 8'h6A; sm8 = 1'b1; iv8 = 1'b1;
      @(posedge clk);
      q8.push_back(model8(8'hB5, 8'h6A, 1'b1));
      #1;
      n = 0;
      while (ov8 !== 1'b1 && n < 40) begin
         a8  = 8'($urandom_range(0, 255));
         b8  = 8'($urandom_range(0, 255));
         sm8 = 1'($urandom_range(0, 1));
         iv8 = 1'($urandom_range(0, 1));
         or8 = 1'($urandom_range(0, 1));
         @(posedge clk); #1; n++;
      end
      iv8 = 1'b0; or8 = 1'b0;
      checks++;
      if (n != 8) begin
         errors++; $display("FAIL ignored_latency got %0d want 8", n);
      end
      e = q8.pop_front();
      checks++;
      if (r8 !== e) begin
         errors++; $display("FAIL ignored_res got %h want %h", r8, e);
      end
      or8 = 1'b1;
      @(posedge clk); #1;
      or8 = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [7:0] oa[4];
      logic [7:0] ob[4];
      logic       os[4];
      int acc_t[4];
      int idx, got;
      logic adv;
      logic [15:0] e;
      oa = '{8'd17, 8'hF0, 8'd200, 8'h81};
      ob = '{8'd19, 8'h0C, 8'd250, 8'h7F};
      os = '{1'b0, 1'b1, 1'b0, 1'b1};
      acc_t = '{0, 0, 0, 0};
      idx = 0; got = 0; adv = 1'b0;
      a8 = oa[0]; b8 = ob[0]; sm8 = os[0]; iv8 = 1'b1; or8 = 1'b1;
      for (int cyc = 0; cyc < 200 && got < 4; cyc++) begin
         if (ov8 === 1'b1) begin
            checks++;
            if (q8.size() == 0) begin
               errors++; $display("FAIL b2b_unexpected_out got res=%h want none", r8);
            end else begin
               e = q8.pop_front();
               if (r8 !== e) begin
                  errors++; $display("FAIL b2b_res_%0d got %h want %h", got, r8, e);
               end
            end
            got++;
         end
         if (ir8 === 1'b1 && idx < 4) begin
            q8.push_back(model8(a8, b8, sm8));
            acc_t[idx] = cyc;
            idx++;
            adv = 1'b1;
         end
         @(posedge clk); #1;
         if (adv) begin
            adv = 1'b0;
            if (idx < 4) begin
               a8 = oa[idx]; b8 = ob[idx]; sm8 = os[idx];
            end else begin
               iv8 = 1'b0;
            end
         end
      end
      iv8 = 1'b0; or8 = 1'b0;
      checks++;
      if (got != 4) begin
         errors++; $display("FAIL b2b_count got %0d want 4", got);
      end
      for (int i = 1; i < 4; i++) begin
         checks++;
         if (acc_t[i] - acc_t[i-1] != 10) begin
            errors++; $display("FAIL b2b_interval_%0d got %0d want 10",
                               i, acc_t[i] - acc_t[i-1]);
         end
      end
      q8.delete();
   endtask

   task automatic test_reset_mid_run();
      logic seen;
      a8 = 8'd200; b8 = 8'd3; sm8 = 1'b0; iv8 = 1'b1;
      @(posedge clk); #1; iv8 = 1'b0;
      repeat (3) @(posedge clk);
      #3 rst = 1'b1;
      #2 rst = 1'b0;
      checks++;
      if (ir8 !== 1'b1 || ov8 !== 1'b0) begin
         errors++; $display("FAIL mid_run_reset got ir=%b ov=%b want ir=1 ov=0", ir8, ov8);
      end
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (ov8 === 1'b1) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++; $display("FAIL aborted_out_valid got 1 want 0");
      end
      do_op8(8'd7, 8'd9, 1'b0, 16'h003F, "after_reset_7x9");
   endtask

   task automatic test_n3();
      do_op3(3'd7,    3'd7,    1'b0, 6'd49,  "n3_7x7");
      do_op3(3'b100,  3'b100,  1'b1, 6'd16,  "n3_m4xm4");
      do_op3(3'd3,    3'b100,  1'b1, 6'h34,  "n3_3xm4");
   endtask

   initial begin
      test_reset();
      test_unsigned();
      test_signed();
      test_random();
      test_backpressure();
      test_ignored_inputs();
      test_back_to_back();
      test_reset_mid_run();
      test_n3();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
